// File: rtl/row_scan_pkg.sv
// Shared types and sizes for the row scan encoder.
package row_scan_pkg;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  typedef enum logic {IDLE, EMIT} scan_state_t;

  typedef logic [WIDTH-1:0] row_t;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of a row,
// plus flags telling whether any bit is set and whether exactly one is set.
module lowest_set_index
  import row_scan_pkg::*;
(
  input  row_t             i_row,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any,
  output logic             o_single
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_row[i]) o_idx = IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  always_comb begin
    o_any    = |i_row;
    o_single = o_any && ((i_row & (i_row - row_t'(1))) == '0);
  end

endmodule

// File: rtl/row_scan_encoder.sv
// Row scan encoder: turns a pixel-row bitmap into a stream of column
// indices, lowest column first, one per valid/ready transfer.
//
// state | meaning
// IDLE  | waiting for a load; busy=0, valid=0
// EMIT  | pending row non-empty; presenting lowest remaining index
module row_scan_encoder
  import row_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] row_in,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [IDX_W-1:0] col,
  output logic             last,
  output logic [IDX_W:0]   count,
  output logic             done,
  output logic             empty
);

  scan_state_t      r_state, w_state_nxt;
  row_t             r_pending, w_pending_nxt;
  logic [IDX_W:0]   r_count, w_count_nxt;
  logic             r_done, w_done_nxt;
  logic             r_empty, w_empty_nxt;

  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_single;
  logic             w_emit;

  lowest_set_index u_lsi (
    .i_row    (r_pending),
    .o_idx    (w_idx),
    .o_any    (w_any),
    .o_single (w_single)
  );

  // State, pending row, count and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_empty   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
      r_done    <= w_done_nxt;
      r_empty   <= w_empty_nxt;
    end
  end

  // Next-state logic; loads are only looked at in IDLE, so a load during
  // EMIT (even on the final handshake) is dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_count_nxt   = r_count;
    w_done_nxt    = 1'b0;
    w_empty_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_count_nxt = '0;
          if (row_in != '0) begin
            w_pending_nxt = row_in;
            w_state_nxt   = EMIT;
          end else begin
            w_empty_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (ready) begin
          w_pending_nxt = r_pending & ~(row_t'(1) << w_idx);
          w_count_nxt   = r_count + {{IDX_W{1'b0}}, 1'b1};
          if (w_single) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs depend only on registered state; ready/load never reach them.
  always_comb begin
    w_emit = (r_state == EMIT);
    busy   = w_emit;
    valid  = w_emit;
    col    = (w_emit && w_any) ? w_idx : '0;
    last   = w_emit && w_single;
    count  = r_count;
    done   = r_done;
    empty  = r_empty;
  end

endmodule

// File: tb/tb_row_scan_encoder.sv
// Directed bench for row_scan_encoder with hand-computed expectations.
module tb_row_scan_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] row_in;
  logic        busy;
  logic        valid;
  logic        ready;
  logic [3:0]  col;
  logic        last;
  logic [4:0]  count;
  logic        done;
  logic        empty;

  int n_tests = 0;
  int n_fail  = 0;

  row_scan_encoder dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .row_in (row_in),
    .busy   (busy),
    .valid  (valid),
    .ready  (ready),
    .col    (col),
    .last   (last),
    .count  (count),
    .done   (done),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs all outputs: {busy,valid,col,last,count,done,empty}
  function automatic logic [31:0] outs();
    return {18'd0, busy, valid, col, last, count, done, empty};
  endfunction

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    ready  = 1'b0;
    row_in = 16'h0000;

    // Reset then idle
    step();
    chk("reset_c1", outs(), 32'd0);
    step();
    chk("reset_c2", outs(), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", outs(), 32'd0);
    end

    // Sparse row 0x8410 with ready held high: cols 4, 10, 15
    ready = 1'b1;
    load = 1'b1; row_in = 16'h8410;
    step();
    load = 1'b0;
    chk("sp_valid", {busy, valid}, 2'b11);
    chk("sp_col4", {col, last}, {4'd4, 1'b0});
    step();
    chk("sp_col10", {col, last}, {4'd10, 1'b0});
    step();
    chk("sp_col15", {col, last, valid}, {4'd15, 1'b1, 1'b1});
    step();
    chk("sp_done", {done, valid, busy}, 3'b100);
    chk("sp_count", count, 5'd3);
    chk("sp_col_idle", {col, last}, 5'd0);
    step();
    chk("sp_done_pulse", done, 1'b0);
    chk("sp_count_hold", count, 5'd3);

    // Backpressure on 0x0003
    ready = 1'b0;
    load = 1'b1; row_in = 16'h0003;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {valid, col, last}, {1'b1, 4'd0, 1'b0});
      chk("bp_count0", count, 5'd0);
      if (i < 2) step();
    end
    ready = 1'b1;
    step();
    chk("bp_col1", {valid, col, last}, {1'b1, 4'd1, 1'b1});
    chk("bp_count1", count, 5'd1);
    step();
    chk("bp_done", {done, valid}, 2'b10);
    chk("bp_count2", count, 5'd2);

    // Full row
    load = 1'b1; row_in = 16'hFFFF;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("full_col", {valid, col, last}, {1'b1, 4'(i), (i == 15)});
      chk("full_done_low", done, 1'b0);
      step();
    end
    chk("full_done", {done, valid, busy}, 3'b100);
    chk("full_count", count, 5'd16);

    // Empty row
    step();
    load = 1'b1; row_in = 16'h0000;
    step();
    load = 1'b0;
    chk("empty_pulse", {empty, done, valid, busy}, 4'b1000);
    chk("empty_count", count, 5'd0);
    step();
    chk("empty_clear", {empty, valid, busy}, 3'b000);

    // Ignored load during EMIT, then back-to-back in the done cycle
    ready = 1'b0;
    load = 1'b1; row_in = 16'h0101;
    step();
    chk("ign_col0", {valid, col, last}, {1'b1, 4'd0, 1'b0});
    row_in = 16'h8000;   // load still high: must be ignored
    ready = 1'b1;
    step();
    chk("ign_col8", {valid, col, last}, {1'b1, 4'd8, 1'b1});
    step();               // load high through the final handshake
    chk("ign_final_done", {done, valid, busy}, 3'b100);
    chk("ign_count", count, 5'd2);
    step();               // load in the done cycle is accepted
    load = 1'b0;
    chk("b2b_col15", {busy, valid, col, last}, {1'b1, 1'b1, 4'd15, 1'b1});
    chk("b2b_count0", count, 5'd0);
    step();
    chk("b2b_done", {done, valid}, 2'b10);
    chk("b2b_count1", count, 5'd1);
    step();

    // Reset mid-scan
    load = 1'b1; row_in = 16'h00F0;
    step();
    load = 1'b0;
    chk("rst_col4", {valid, col}, {1'b1, 4'd4});
    step();
    chk("rst_col5", {valid, col, count}, {1'b1, 4'd5, 5'd1});
    reset = 1'b1;
    step();
    chk("rst_mid", outs(), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_no_done", outs(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/row_scan_encoder.md
# row_scan_encoder

Serial encoder that converts a 16-bit one-per-column pixel row back into 4-bit column indices: the inverse direction of the column-choice decoder. A loaded row is scanned lowest column first, and each set bit is emitted as an index over a valid/ready handshake, one index per accepted transfer. It sits between the asteroid row buffer and the collision/scoring logic, which consumes column numbers rather than bitmaps.

## Interface
- WIDTH, 16, number of columns in a row
- IDX_W, 4, index width, equal to $clog2(WIDTH)
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  capture row_in; honoured only while busy=0
- row_in  input  WIDTH  row bitmap; bit i set means column i is lit
- busy  output  1  high from the cycle after an accepted non-empty load until the cycle after the last handshake
- valid  output  1  col holds a pending index
- ready  input  1  consumer accepts col this cycle when valid=1
- col  output  IDX_W  index of the lowest remaining set bit; 0 when valid=0
- last  output  1  high with valid when col is the final remaining bit
- count  output  IDX_W+1  indices accepted so far for the current row; holds after done
- done  output  1  one-cycle pulse after the final handshake
- empty  output  1  one-cycle pulse after a load of an all-zero row

## Operation
- States: IDLE, EMIT.
- IDLE: busy=0, valid=0. On load=1:
  - row_in != 0: pending <= row_in, count <= 0, go to EMIT.
  - row_in == 0: empty=1 on the next cycle, count <= 0, stay in IDLE.
- EMIT: busy=1, valid=1. col = lowest set index of pending. last = (pending has exactly one bit set).
- On valid&&ready: clear bit col in pending, count <= count+1.
  - If last=1: go to IDLE, and done=1 on the next cycle.
- valid=1 with ready=0: col, last and pending hold. valid does not drop.
- load during EMIT, including the final-handshake cycle: ignored. The producer must wait for busy=0.
- count saturates naturally at WIDTH (a full row gives count=16). The IDX_W+1 width is required so that 16 fits.
- done and empty never assert in the same cycle. Neither asserts without a preceding load.

## Timing
- Reset values: state=IDLE, pending=0, busy=0, valid=0, col=0, last=0, count=0, done=0, empty=0.
- Reset mid-scan abandons the row. All outputs take their reset values on the next cycle.
- Load latency: load at edge N gives valid/busy high in cycle N+1.
- Throughput: one index per cycle while ready is held high. A row with k set bits finishes in k cycles after valid rises, and done pulses in cycle N+1+k.
- col, last and valid are functions of registered state only. There is no combinational path from ready or load to any output.
- Back-to-back rows: the earliest next load is the cycle in which done is high. That load is accepted because busy=0 in that cycle, and valid rises on the following cycle.

## Structure
- Shared package row_scan_pkg holds:
  - localparams WIDTH=16 and IDX_W=4;
  - typedef enum logic {IDLE, EMIT} scan_state_t;
  - typedef logic [WIDTH-1:0] row_t.
- One sub-module: lowest_set_index, a combinational priority encoder.
  - Input: row_t. Outputs: IDX_W-bit index, any-set flag, single-bit flag.
  - Used by the top level to generate col and last.
- Top level contains the FSM, the pending register, the count register, and the done/empty pulse registers.

## Test plan
- Reset then idle: reset=1 for 2 cycles, then load=0 for 5 cycles -> every output is 0 throughout.
- Sparse row, ready held high: load row_in=16'b1000_0100_0001_0000 -> col=4, 10, 15 on consecutive cycles; last=1 only with 15; done pulses once; count=3.
- Backpressure: load 16'h0003, ready=0 for 3 cycles then 1 -> col=0 holds with valid=1 for 3 cycles, then col=1 with last=1, then done.
- Full and empty rows:
  - load 16'hFFFF -> 16 indices 0..15, count=16.
  - load 16'h0000 -> empty pulses for 1 cycle; valid and busy stay 0.
- Ignored load and back-to-back: with 16'h0101 in flight, pulse load with 16'h8000 -> only 0 and 8 are emitted. Then load 16'h8000 in the done cycle -> col=15 on the next cycle.
- Reset mid-scan: load 16'h00F0, accept col=4, assert reset -> next cycle valid=0, busy=0, count=0, with no done pulse.
